// File: rtl/sisc_fetch.sv
// Instruction fetch/sequencing for SISC: req/ack instruction memory in, registered IR/PC with valid/take out to ctrl.
// Optional one-entry prefetch buffer and DRAIN state when SISC_FETCH_PREFETCH_EN is defined.
module sisc_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter int                BR_OFF_W = 16,
    parameter logic [ADDR_W-1:0] RST_VEC  = '0
) (
    input  logic                clk,
    input  logic                rst_f,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  ir_out,
    output logic                ir_valid,
    output logic [ADDR_W-1:0]   pc_out,
    input  logic                ir_take,
    input  logic                br_take,
    input  logic                br_sel,
    input  logic [BR_OFF_W-1:0] br_off
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_FETCH,
        ST_HOLD
`ifdef SISC_FETCH_PREFETCH_EN
        , ST_DRAIN
`endif
    } state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 ir_vld_q, ir_vld_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    pc_seq;
    logic [ADDR_W-1:0]    next_addr;
`ifdef SISC_FETCH_PREFETCH_EN
    logic [INSTR_W-1:0]   pf_data_q, pf_data_d;
    logic                 pf_vld_q, pf_vld_d;
    logic [ADDR_W-1:0]    tgt_q, tgt_d;
    logic                 ack_hit;
`endif

    assign pc_seq = pc_q + ADDR_W'(1);

    // Redirect target; casts give modulo-2^ADDR_W arithmetic for any BR_OFF_W.
    always_comb begin
        if (!br_take) begin
            next_addr = pc_seq;
        end else if (br_sel) begin
            next_addr = ADDR_W'(br_off);
        end else begin
            next_addr = pc_seq + ADDR_W'($signed(br_off));
        end
    end

`ifdef SISC_FETCH_PREFETCH_EN
    assign ack_hit = req_q & imem_ack;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        ir_vld_d = ir_vld_q;
        pc_d     = pc_q;
`ifdef SISC_FETCH_PREFETCH_EN
        pf_data_d = pf_data_q;
        pf_vld_d  = pf_vld_q;
        tgt_d     = tgt_q;
`endif
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = RST_VEC;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d     = imem_rdata;
                    pc_d     = addr_q;
                    ir_vld_d = 1'b1;
                    state_d  = ST_HOLD;
`ifdef SISC_FETCH_PREFETCH_EN
                    req_d    = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
`else
                    req_d    = 1'b0;
`endif
                end
            end
`ifdef SISC_FETCH_PREFETCH_EN
            // In HOLD exactly one of pf_vld_q / req_q is set: the prefetch is either buffered or in flight.
            ST_HOLD: begin
                if (ir_take) begin
                    if (br_take) begin
                        pf_vld_d = 1'b0;
                        ir_vld_d = 1'b0;
                        if (req_q && !imem_ack) begin
                            tgt_d   = next_addr;
                            state_d = ST_DRAIN;
                        end else begin
                            req_d   = 1'b1;
                            addr_d  = next_addr;
                            state_d = ST_FETCH;
                        end
                    end else if (pf_vld_q) begin
                        ir_d     = pf_data_q;
                        pc_d     = pc_seq;
                        pf_vld_d = 1'b0;
                        req_d    = 1'b1;
                        addr_d   = pc_seq + ADDR_W'(1);
                    end else if (ack_hit) begin
                        // Prefetch lands on the take edge: forward straight into the IR.
                        ir_d   = imem_rdata;
                        pc_d   = addr_q;
                        req_d  = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        ir_vld_d = 1'b0;
                        state_d  = ST_FETCH;
                    end
                end else if (ack_hit) begin
                    pf_data_d = imem_rdata;
                    pf_vld_d  = 1'b1;
                    req_d     = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b1;
                    addr_d  = tgt_q;
                    state_d = ST_FETCH;
                end
            end
`else
            ST_HOLD: begin
                if (ir_take) begin
                    ir_vld_d = 1'b0;
                    req_d    = 1'b1;
                    addr_d   = next_addr;
                    state_d  = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q  <= ST_RST;
            req_q    <= 1'b0;
            addr_q   <= RST_VEC;
            ir_q     <= '0;
            ir_vld_q <= 1'b0;
            pc_q     <= RST_VEC;
`ifdef SISC_FETCH_PREFETCH_EN
            pf_data_q <= '0;
            pf_vld_q  <= 1'b0;
            tgt_q     <= RST_VEC;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            ir_vld_q <= ir_vld_d;
            pc_q     <= pc_d;
`ifdef SISC_FETCH_PREFETCH_EN
            pf_data_q <= pf_data_d;
            pf_vld_q  <= pf_vld_d;
            tgt_q     <= tgt_d;
`endif
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir_out    = ir_q;
    assign ir_valid  = ir_vld_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed testbench for sisc_fetch; memory returns 0x10000000 + address.
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic [15:0] pc_out;
    logic        ir_take;
    logic        br_take;
    logic        br_sel;
    logic [15:0] br_off;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h1000_0000 + {16'h0000, imem_addr};

    sisc_fetch dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_out     (ir_out),
        .ir_valid   (ir_valid),
        .pc_out     (pc_out),
        .ir_take    (ir_take),
        .br_take    (br_take),
        .br_sel     (br_sel),
        .br_off     (br_off)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_f = 1'b0; imem_ack = 1'b1; ir_take = 1'b0; br_take = 1'b0; br_sel = 1'b0; br_off = 16'h0;
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 16'h0) begin n_err++; $display("FAIL rst_addr got %h want 0000", imem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", ir_valid); end
        n_cmp++; if (ir_out !== 32'h0) begin n_err++; $display("FAIL rst_ir got %h want 0", ir_out); end
        n_cmp++; if (pc_out !== 16'h0) begin n_err++; $display("FAIL rst_pc got %h want 0000", pc_out); end
        rst_f = 1'b1;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin n_err++; $display("FAIL first_req got %b@%h want 1@0000", imem_req, imem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL first_valid_early got %b want 0", ir_valid); end
        tick();
        n_cmp++; if (ir_valid !== 1'b1 || ir_out !== 32'h1000_0000 || pc_out !== 16'h0)
            begin n_err++; $display("FAIL first_ir got v%b %h pc %h want v1 10000000 pc 0000", ir_valid, ir_out, pc_out); end
`ifdef SISC_FETCH_PREFETCH_EN
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin n_err++; $display("FAIL first_prefetch got %b@%h want 1@0001", imem_req, imem_addr); end
`else
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL first_req_drop got %b want 0", imem_req); end
`endif
    endtask

`ifdef SISC_FETCH_PREFETCH_EN
    task automatic test_prefetch();
        ir_take = 1'b1; imem_ack = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 16'(k) || ir_out !== 32'h1000_0000 + k)
                begin n_err++; $display("FAIL b2b_%0d got v%b pc %h ir %h want v1 pc %h", k, ir_valid, pc_out, ir_out, k); end
        end
        ir_take = 1'b0; imem_ack = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004 || pc_out !== 16'h0003)
            begin n_err++; $display("FAIL pf_pending got %b@%h pc %h want 1@0004 pc 0003", imem_req, imem_addr, pc_out); end
        ir_take = 1'b1; br_take = 1'b1; br_sel = 1'b1; br_off = 16'h0040;
        tick();
        n_cmp++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0004)
            begin n_err++; $display("FAIL drain got v%b %b@%h want v0 1@0004", ir_valid, imem_req, imem_addr); end
        ir_take = 1'b0; br_take = 1'b0; br_sel = 1'b0; imem_ack = 1'b1;
        tick();
        n_cmp++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040)
            begin n_err++; $display("FAIL drain_exit got v%b %b@%h want v0 1@0040", ir_valid, imem_req, imem_addr); end
        tick();
        n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 16'h0040 || ir_out !== 32'h1000_0040)
            begin n_err++; $display("FAIL target got v%b pc %h ir %h want v1 pc 0040 ir 10000040", ir_valid, pc_out, ir_out); end
        tick();
        n_cmp++; if (imem_req !== 1'b0 || pc_out !== 16'h0040)
            begin n_err++; $display("FAIL pf_buffered got req %b pc %h want 0 pc 0040", imem_req, pc_out); end
        imem_ack = 1'b0; ir_take = 1'b1;
        tick();
        ir_take = 1'b0;
        n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 16'h0041 || ir_out !== 32'h1000_0041 || imem_addr !== 16'h0042)
            begin n_err++; $display("FAIL pf_take got v%b pc %h ir %h addr %h want v1 0041 10000041 0042", ir_valid, pc_out, ir_out, imem_addr); end
    endtask
`else
    task automatic test_wait_states();
        for (int i = 1; i <= 4; i++) begin
            ir_take = 1'b1; imem_ack = 1'b0;
            tick();
            // garbage take/branch while nothing is valid must be ignored
            br_take = 1'b1; br_sel = 1'b1; br_off = 16'h1234;
            for (int w = 0; w < 3; w++) begin
                tick();
                n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'(i) || ir_valid !== 1'b0)
                    begin n_err++; $display("FAIL wait_%0d_%0d got %b@%h v%b want 1@%h v0", i, w, imem_req, imem_addr, ir_valid, i); end
            end
            ir_take = 1'b0; br_take = 1'b0; br_sel = 1'b0; imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
            n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 16'(i) || ir_out !== 32'h1000_0000 + i)
                begin n_err++; $display("FAIL wait_ir_%0d got v%b pc %h ir %h want v1 pc %h", i, ir_valid, pc_out, ir_out, i); end
        end
        imem_ack = 1'b1;
        tick(); tick();
        n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 16'h0004 || imem_req !== 1'b0)
            begin n_err++; $display("FAIL stray_ack got v%b pc %h req %b want v1 0004 0", ir_valid, pc_out, imem_req); end
        imem_ack = 1'b0; ir_take = 1'b1;
        tick();
        ir_take = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005)
            begin n_err++; $display("FAIL seq_next got %b@%h want 1@0005", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
    endtask

    task automatic test_rel_branch();
        ir_take = 1'b1; br_take = 1'b1; br_sel = 1'b1; br_off = 16'h0010; imem_ack = 1'b0;
        tick();
        ir_take = 1'b0; br_take = 1'b0; imem_ack = 1'b1;
        tick();
        n_cmp++; if (pc_out !== 16'h0010 || ir_out !== 32'h1000_0010)
            begin n_err++; $display("FAIL abs_0010 got pc %h ir %h want 0010 10000010", pc_out, ir_out); end
        ir_take = 1'b1; br_take = 1'b1; br_sel = 1'b0; br_off = 16'hFFFC; imem_ack = 1'b0;
        tick();
        ir_take = 1'b0; br_take = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h000D)
            begin n_err++; $display("FAIL rel_back got %b@%h want 1@000D", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
        n_cmp++; if (pc_out !== 16'h000D || ir_out !== 32'h1000_000D)
            begin n_err++; $display("FAIL rel_ir got pc %h ir %h want 000D 1000000D", pc_out, ir_out); end
    endtask

    task automatic test_abs_wrap();
        ir_take = 1'b1; br_take = 1'b1; br_sel = 1'b1; br_off = 16'hFFFF; imem_ack = 1'b0;
        tick();
        ir_take = 1'b0; br_take = 1'b0; br_sel = 1'b0;
        n_cmp++; if (imem_addr !== 16'hFFFF) begin n_err++; $display("FAIL abs_ffff got %h want FFFF", imem_addr); end
        imem_ack = 1'b1;
        tick();
        n_cmp++; if (pc_out !== 16'hFFFF || ir_out !== 32'h1000_FFFF)
            begin n_err++; $display("FAIL abs_ir got pc %h ir %h want FFFF 1000FFFF", pc_out, ir_out); end
        ir_take = 1'b1; imem_ack = 1'b0;
        tick();
        ir_take = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
            begin n_err++; $display("FAIL wrap got %b@%h want 1@0000", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        ir_take = 1'b1; imem_ack = 1'b0;
        tick();
        ir_take = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001)
            begin n_err++; $display("FAIL mid_pending got %b@%h want 1@0001", imem_req, imem_addr); end
        rst_f = 1'b0; imem_ack = 1'b1;
        tick();
        n_cmp++; if (ir_valid !== 1'b0 || pc_out !== 16'h0 || ir_out !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 16'h0)
            begin n_err++; $display("FAIL mid_rst got v%b pc %h ir %h %b@%h want all reset", ir_valid, pc_out, ir_out, imem_req, imem_addr); end
        rst_f = 1'b1; imem_ack = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin n_err++; $display("FAIL refetch got %b@%h want 1@0000", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
        n_cmp++; if (ir_valid !== 1'b1 || pc_out !== 16'h0 || ir_out !== 32'h1000_0000)
            begin n_err++; $display("FAIL refetch_ir got v%b pc %h ir %h want v1 0000 10000000", ir_valid, pc_out, ir_out); end
    endtask

    task automatic test_back_to_back();
        int vcnt;
        vcnt = 0;
        ir_take = 1'b1; imem_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ir_valid === 1'b1) vcnt++;
        end
        ir_take = 1'b0;
        n_cmp++; if (vcnt !== 4) begin n_err++; $display("FAIL b2b_rate got %0d valid cycles want 4", vcnt); end
        n_cmp++; if (pc_out !== 16'h0004 || ir_valid !== 1'b1)
            begin n_err++; $display("FAIL b2b_pc got pc %h v%b want 0004 v1", pc_out, ir_valid); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SISC_FETCH_PREFETCH_EN
        test_prefetch();
`else
        test_wait_states();
        test_rel_branch();
        test_abs_wrap();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
